// File: rtl/vga_sync_monitor_if.sv
// Sync inputs and recovered timing/status outputs between a VGA timing source and its monitor.
interface vga_sync_monitor_if;
    logic       pix_ce;
    logic       hSync;
    logic       vSync;
    logic [9:0] pix_x;
    logic [9:0] pix_y;
    logic       active;
    logic       locked;
    logic       h_err;
    logic       v_err;
    logic [3:0] err_count;

    modport master (output pix_ce, hSync, vSync,
                    input  pix_x, pix_y, active, locked, h_err, v_err, err_count);
    modport slave  (input  pix_ce, hSync, vSync,
                    output pix_x, pix_y, active, locked, h_err, v_err, err_count);
endinterface

// File: rtl/vga_sync_monitor.sv
// Receive-side VGA timing checker: measures hSync/vSync against the expected line/frame
// geometry, recovers pixel coordinates and reports lock and error status.
module vga_sync_monitor #(
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned H_ACT       = 640,
    parameter int unsigned H_TOTAL     = 800,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned V_ACT       = 480,
    parameter int unsigned V_TOTAL     = 525,
    parameter int unsigned LOCK_FRAMES = 2
) (
    input  logic              ClkPort,
    input  logic              Reset,
    vga_sync_monitor_if.slave bus
);
    localparam logic [9:0] CMAX     = 10'h3FF;
    localparam logic [9:0] H_SYNC_C = 10'(H_SYNC);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_START  = 10'(H_SYNC + H_BP);
    localparam logic [9:0] H_END    = 10'(H_SYNC + H_BP + H_ACT);
    localparam logic [9:0] V_SYNC_C = 10'(V_SYNC);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_START  = 10'(V_SYNC + V_BP);
    localparam logic [9:0] V_END    = 10'(V_SYNC + V_BP + V_ACT);
    localparam logic [3:0] LOCK_C   = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {ACQUIRE, TRACK, LOCKED} state_t;

    state_t     state_q;
    logic       hs_q, hs_p, vs_q, vs_p;
    logic [9:0] hcnt_q, vcnt_q, vlow_q;
    logic       vs_pend_q, line_seen_q, frame_seen_q, frame_bad_q;
    logic [3:0] good_q, err_cnt_q;
    logic       h_err_q, v_err_q, locked_q, active_q;
    logic [9:0] pix_x_q, pix_y_q;

    logic       hfall, hrise, vfall, vrise, frame_edge;
    logic       h_bad, v_bad, bad_now, in_win;
    logic [9:0] hcnt_d, vcnt_d, vlow_d;
    logic [3:0] good_inc;

    always_comb begin
        hfall      = hs_p & ~hs_q;
        hrise      = ~hs_p & hs_q;
        vfall      = vs_p & ~vs_q;
        vrise      = ~vs_p & vs_q;
        // A frame starts on the first hfall at or after a vSync fall.
        frame_edge = hfall & (vs_pend_q | vfall);

        hcnt_d = hfall ? '0 : ((hcnt_q == CMAX) ? CMAX : hcnt_q + 10'd1);
        vcnt_d = vcnt_q;
        if (hfall)
            vcnt_d = frame_edge ? '0 : ((vcnt_q == CMAX) ? CMAX : vcnt_q + 10'd1);

        // Lines begun while vSync is low, including one that starts on the vfall sample.
        vlow_d = vlow_q;
        if (vfall)
            vlow_d = {9'd0, hfall};
        else if (hfall && !vs_q && vlow_q != CMAX)
            vlow_d = vlow_q + 10'd1;

        h_bad   = (hfall & line_seen_q & (hcnt_q != H_LAST)) |
                  (hrise & (hcnt_d != H_SYNC_C));
        v_bad   = (frame_edge & frame_seen_q & (vcnt_q != V_LAST)) |
                  (vrise & (vlow_q != V_SYNC_C));
        bad_now = h_bad | v_bad;

        in_win   = locked_q && (hcnt_q >= H_START) && (hcnt_q < H_END) &&
                   (vcnt_q >= V_START) && (vcnt_q < V_END);
        good_inc = good_q + 4'd1;
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            hs_q      <= 1'b1;
            hs_p      <= 1'b1;
            vs_q      <= 1'b1;
            vs_p      <= 1'b1;
            hcnt_q    <= '0;
            vcnt_q    <= '0;
            vlow_q    <= '0;
            vs_pend_q <= 1'b0;
            active_q  <= 1'b0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
        end else if (bus.pix_ce) begin
            hs_q   <= bus.hSync;
            hs_p   <= hs_q;
            vs_q   <= bus.vSync;
            vs_p   <= vs_q;
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            vlow_q <= vlow_d;
            if (hfall)
                vs_pend_q <= 1'b0;
            else if (vfall)
                vs_pend_q <= 1'b1;
            active_q <= in_win;
            pix_x_q  <= in_win ? hcnt_q - H_START : '0;
            pix_y_q  <= in_win ? vcnt_q - V_START : '0;
        end
    end

    always_ff @(posedge ClkPort or posedge Reset) begin
        if (Reset) begin
            state_q      <= ACQUIRE;
            good_q       <= '0;
            err_cnt_q    <= '0;
            h_err_q      <= 1'b0;
            v_err_q      <= 1'b0;
            locked_q     <= 1'b0;
            line_seen_q  <= 1'b0;
            frame_seen_q <= 1'b0;
            frame_bad_q  <= 1'b0;
        end else if (bus.pix_ce) begin
            if (h_bad) h_err_q <= 1'b1;
            if (v_bad) v_err_q <= 1'b1;
            frame_bad_q <= frame_edge ? 1'b0 : (frame_bad_q | bad_now);
            case (state_q)
                ACQUIRE: begin
                    good_q <= '0;
                    if (frame_edge) begin
                        state_q      <= TRACK;
                        h_err_q      <= 1'b0;
                        v_err_q      <= 1'b0;
                        line_seen_q  <= 1'b1;
                        frame_seen_q <= 1'b1;
                    end
                end
                TRACK: begin
                    // The boundary sample's own checks belong to the frame that is ending.
                    if (frame_edge) begin
                        if (frame_bad_q | bad_now) begin
                            good_q <= '0;
                        end else begin
                            good_q <= good_inc;
                            if (good_inc == LOCK_C) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (bad_now) begin
                        state_q  <= ACQUIRE;
                        locked_q <= 1'b0;
                        if (err_cnt_q != 4'hF) err_cnt_q <= err_cnt_q + 4'd1;
                    end
                end
                default: begin
                    state_q  <= ACQUIRE;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.pix_x     = pix_x_q;
    assign bus.pix_y     = pix_y_q;
    assign bus.active    = active_q;
    assign bus.locked    = locked_q;
    assign bus.h_err     = h_err_q;
    assign bus.v_err     = v_err_q;
    assign bus.err_count = err_cnt_q;
endmodule
